// File: rtl/tt_um_serial_adder.sv
// tt_um_serial_adder: bit-serial WIDTH-bit adder tile, operands loaded bytewise, summed LSB-first one bit per clock
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   ena      tile enable (ignored)
//   ui_in    write data byte
//   uio_in   [0] wr, [1] opsel (0=A, 1=B), [2] start, [3] cin, [5:4] byte index
//   uo_out   selected byte of the last completed result (0 for out-of-range index)
//   uio_out  [7] busy, [6] cout
//   uio_oe   constant 8'hC0
//
// Optional feature: define SERIAL_ADDER_SUB_EN so that opsel=1 at start computes A-B
// (B inverted, carry seeded with 1; cout=1 means no borrow).
module tt_um_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int NBYTES = WIDTH / 8;
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, wa_q, wa_d, wb_q, wb_d, sum_q, sum_d, res_q, res_d;
    logic c_q, c_d, cout_q, cout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic wr, opsel, start, cin, s, cy, unused_ok;
    logic [1:0] idx;
    assign wr = uio_in[0];
    assign opsel = uio_in[1];
    assign start = uio_in[2];
    assign cin = uio_in[3];
    assign idx = uio_in[5:4];
    assign s = wa_q[0] ^ wb_q[0] ^ c_q;
    assign cy = (wa_q[0] & wb_q[0]) | (c_q & (wa_q[0] ^ wb_q[0]));
    assign unused_ok = &{1'b0, ena, uio_in[7:6]};
    assign uio_out = {state_q == BUSY, cout_q, 6'b0};
    assign uio_oe = 8'hC0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            wa_q <= '0;
            wb_q <= '0;
            sum_q <= '0;
            res_q <= '0;
            c_q <= 1'b0;
            cout_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            wa_q <= wa_d;
            wb_q <= wb_d;
            sum_q <= sum_d;
            res_q <= res_d;
            c_q <= c_d;
            cout_q <= cout_d;
            cnt_q <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        wa_d = wa_q;
        wb_d = wb_q;
        sum_d = sum_q;
        res_d = res_q;
        c_d = c_q;
        cout_d = cout_q;
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = BUSY;
                wa_d = a_q;
                cnt_d = '0;
`ifdef SERIAL_ADDER_SUB_EN
                wb_d = opsel ? ~b_q : b_q;
                c_d = opsel ? 1'b1 : cin;
`else
                wb_d = b_q;
                c_d = cin;
`endif
            end else if (wr) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx == 2'(i) && opsel) b_d[8*i +: 8] = ui_in;
                    if (idx == 2'(i) && !opsel) a_d[8*i +: 8] = ui_in;
                end
            end
        end else begin
            wa_d = wa_q >> 1;
            wb_d = wb_q >> 1;
            c_d = cy;
            sum_d = {s, sum_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            // Publish only on the last bit so uo_out/cout never show a partial sum
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = IDLE;
                res_d = sum_d;
                cout_d = cy;
            end
        end
    end
    always_comb begin
        uo_out = 8'h00;
        for (int i = 0; i < NBYTES; i++) uo_out = (idx == 2'(i)) ? res_q[8*i +: 8] : uo_out;
    end
endmodule

// File: tb/tb_tt_um_serial_adder.sv
// tb_tt_um_serial_adder: directed self-checking bench for 8- and 16-bit serial adders
module tb_tt_um_serial_adder;
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
    logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
    logic [7:0] uo8, uio_o8, oe8, uo16, uio_o16, oe16;
    int total = 0, bad = 0, n;
    tt_um_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo8), .uio_out(uio_o8), .uio_oe(oe8)
    );
    tt_um_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo16), .uio_out(uio_o16), .uio_oe(oe16)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic opsel, input logic [1:0] idx, input logic [7:0] d);
        ui_in = d;
        uio_in = {2'b00, idx, 1'b0, 1'b0, opsel, 1'b1};
        tick();
        uio_in = 8'h00;
    endtask
    task automatic go(input logic cin, input logic opsel);
        uio_in = {4'b0000, cin, 1'b1, opsel, 1'b0};
        tick();
        uio_in = 8'h00;
    endtask
    task automatic wait_idle(input bit w16, output int cnt);
        cnt = 0;
        while ((w16 ? uio_o16[7] : uio_o8[7]) && cnt < 100) begin
            tick();
            cnt++;
        end
        if (cnt >= 100) check("busy_timeout", 32'(cnt), 32'(0));
    endtask
    task automatic rd(input logic [1:0] idx);
        uio_in[5:4] = idx;
        #1;
    endtask
    task automatic reset();
        uio_in = 8'h00;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask
    initial begin
        reset();
        check("rst_uo8", uo8, 8'h00);
        check("rst_uio8", uio_o8, 8'h00);
        check("rst_oe8", oe8, 8'hC0);
        check("rst_uo16", uo16, 8'h00);
        check("rst_oe16", oe16, 8'hC0);
        wr(0, 0, 8'h5A);
        wr(1, 0, 8'h3C);
        go(0, 0);
        check("busy_set", uio_o8[7], 1);
        wait_idle(0, n);
        check("busy_cycles8", 32'(n), 32'(8));
        rd(0);
        check("add_5a_3c", uo8, 8'h96);
        check("cout_5a_3c", uio_o8[6], 0);
        go(1, 0);
        wait_idle(0, n);
        check("add_cin", uo8, 8'h97);
        reset();
        wr(0, 0, 8'hFF);
        wr(0, 1, 8'hFF);
        wr(1, 0, 8'h01);
        wr(1, 3, 8'h55);
        go(0, 0);
        wait_idle(1, n);
        check("busy_cycles16", 32'(n), 32'(16));
        rd(0);
        check("w16_idx0", uo16, 8'h00);
        check("w8_wrap", uo8, 8'h00);
        check("w8_cout", uio_o8[6], 1);
        rd(1);
        check("w16_idx1", uo16, 8'h00);
        check("w16_cout", uio_o16[6], 1);
        rd(2);
        check("w16_idx2", uo16, 8'h00);
        rd(3);
        check("w16_idx3", uo16, 8'h00);
        reset();
        wr(0, 0, 8'h01);
        wr(1, 0, 8'h01);
        go(0, 0);
        repeat (3) tick();
        wr(1, 0, 8'h7F);
        go(0, 0);
        wait_idle(0, n);
        rd(0);
        check("busy_ignore", uo8, 8'h02);
        tick();
        check("no_restart", uio_o8[7], 0);
        go(0, 0);
        wait_idle(0, n);
        check("restart_noreload", uo8, 8'h02);
        wr(1, 0, 8'h7F);
        go(0, 0);
        repeat (4) tick();
        check("mid_busy_prev", uo8, 8'h02);
        wait_idle(0, n);
        check("reload_add", uo8, 8'h80);
        reset();
        wr(0, 0, 8'hF0);
        wr(1, 0, 8'h0F);
        go(0, 0);
        wait_idle(0, n);
        check("add_f0_0f", uo8, 8'hFF);
        go(0, 0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", uio_o8[7], 0);
        check("abort_uo", uo8, 8'h00);
        check("abort_cout", uio_o8[6], 0);
        tick();
        rst_n = 1'b1;
        tick();
        wr(0, 0, 8'h10);
        wr(1, 0, 8'h20);
        go(0, 0);
        wait_idle(0, n);
        check("after_abort", uo8, 8'h30);
        wr(0, 0, 8'h01);
        wr(1, 0, 8'h02);
        uio_in = 8'h04;
        tick();
        repeat (8) tick();
        check("held_idle", uio_o8[7], 0);
        check("held_result", uo8, 8'h03);
        tick();
        check("held_rebusy", uio_o8[7], 1);
        uio_in = 8'h00;
        wait_idle(0, n);
        reset();
        wr(0, 0, 8'h05);
        wr(1, 0, 8'h07);
        go(0, 1);
        wait_idle(0, n);
`ifdef SERIAL_ADDER_SUB_EN
        check("sub_5_7", uo8, 8'hFE);
        check("sub_5_7_cout", uio_o8[6], 0);
`else
        check("opsel_add_5_7", uo8, 8'h0C);
        check("opsel_add_5_7_cout", uio_o8[6], 0);
`endif
        wr(0, 0, 8'h07);
        wr(1, 0, 8'h05);
        go(0, 1);
        wait_idle(0, n);
`ifdef SERIAL_ADDER_SUB_EN
        check("sub_7_5", uo8, 8'h02);
        check("sub_7_5_cout", uio_o8[6], 1);
`else
        check("opsel_add_7_5", uo8, 8'h0C);
        check("opsel_add_7_5_cout", uio_o8[6], 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
